// File: rtl/life_pkg.sv
// ============================================================================
//  Module  : life_pkg
//  Brief   : Shared types and width constants for the Life generation scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package life_pkg;

    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;
    localparam int IW_DEF     = $clog2(GRID_W_DEF * GRID_H_DEF);
    localparam int AW_DEF     = IW_DEF + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_COMMIT = 2'd2
    } life_state_e;

    // Coordinate counters need at least one bit even for a one-cell axis.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/life_mem_arbiter.sv
// ============================================================================
//  Module  : life_mem_arbiter
//  Brief   : Fixed-priority display/engine arbiter with double-buffer bank mux.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module life_mem_arbiter #(
    parameter int IW = 10
) (
    input  logic          front_bank_i,
    input  logic          disp_req_i,
    input  logic [IW-1:0] disp_addr_i,
    input  logic          eng_req_i,
    input  logic [IW-1:0] eng_addr_i,
    input  logic          eng_we_i,
    output logic          disp_gnt_o,
    output logic          eng_gnt_o,
    output logic [IW:0]   mem_addr_o,
    output logic          mem_we_o
);

    logic eng_gnt;

    assign eng_gnt    = eng_req_i & ~disp_req_i;
    assign disp_gnt_o = disp_req_i;
    assign eng_gnt_o  = eng_gnt;
    assign mem_we_o   = eng_gnt & eng_we_i;

    // Engine writes land in the back bank; every read sees the front bank.
    always_comb begin
        mem_addr_o = {front_bank_i, disp_addr_i};
        if (eng_gnt) begin
            mem_addr_o = {(eng_we_i ? ~front_bank_i : front_bank_i), eng_addr_i};
        end
    end

endmodule

`default_nettype wire

// File: rtl/life_gen_scheduler.sv
// ============================================================================
//  Module  : life_gen_scheduler
//  Brief   : Schedules Life generations on frame ticks, sweeps cells for the
//            update engine and flips the display bank on commit.
//            Optional macro LIFE_SCHED_OVERRUN_CNT_EN enables the overrun counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module life_gen_scheduler
    import life_pkg::*;
#(
    parameter  int GRID_W    = GRID_W_DEF,
    parameter  int GRID_H    = GRID_H_DEF,
    parameter  int FRAME_DIV = 8,
    localparam int IW        = $clog2(GRID_W * GRID_H),
    localparam int AW        = IW + 1,
    localparam int XW        = coord_w(GRID_W),
    localparam int YW        = coord_w(GRID_H)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          frame_tick_i,
    input  logic          run_i,
    input  logic          step_i,
    input  logic          disp_req_i,
    input  logic [IW-1:0] disp_addr_i,
    input  logic          eng_req_i,
    input  logic [IW-1:0] eng_addr_i,
    input  logic          eng_we_i,
    input  logic          cell_done_i,
    output logic          disp_gnt_o,
    output logic          eng_gnt_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic          cell_valid_o,
    output logic [XW-1:0] cell_x_o,
    output logic [YW-1:0] cell_y_o,
    output logic          gen_busy_o,
    output logic          front_bank_o,
    output logic          overrun_o,
    output logic [15:0]   gen_count_o,
    output logic [7:0]    overrun_count_o
);

    localparam logic [7:0]    DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(GRID_H - 1);

    life_state_e   state_q;
    logic [7:0]    frame_cnt_q;
    logic          step_pending_q;
    logic          front_bank_q;
    logic [15:0]   gen_count_q;
    logic [XW-1:0] cell_x_q;
    logic [YW-1:0] cell_y_q;
    logic          cell_valid_q;
    logic          overrun_q;
    logic          trigger;
    logic          overrun_hit;

    // A pending step is only honoured on a frame tick it did not arrive with.
    assign trigger     = frame_tick_i & ((run_i & (frame_cnt_q == DIV_LAST)) | step_pending_q);
    assign overrun_hit = trigger & (state_q != S_IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            frame_cnt_q    <= 8'd0;
            step_pending_q <= 1'b0;
            front_bank_q   <= 1'b0;
            gen_count_q    <= 16'd0;
            cell_x_q       <= '0;
            cell_y_q       <= '0;
            cell_valid_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            overrun_q <= overrun_hit;

            if (!run_i) begin
                frame_cnt_q <= 8'd0;
            end else if (frame_tick_i) begin
                frame_cnt_q <= (frame_cnt_q == DIV_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
            end

            if (trigger && (state_q == S_IDLE)) begin
                step_pending_q <= 1'b0;
            end
            if (step_i) begin
                step_pending_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_q      <= S_SWEEP;
                        cell_valid_q <= 1'b1;
                        cell_x_q     <= '0;
                        cell_y_q     <= '0;
                    end
                end
                S_SWEEP: begin
                    if (cell_done_i && cell_valid_q) begin
                        if (cell_x_q == X_LAST) begin
                            cell_x_q <= '0;
                            if (cell_y_q == Y_LAST) begin
                                cell_y_q     <= '0;
                                cell_valid_q <= 1'b0;
                                state_q      <= S_COMMIT;
                            end else begin
                                cell_y_q <= cell_y_q + 1'b1;
                            end
                        end else begin
                            cell_x_q <= cell_x_q + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    front_bank_q <= ~front_bank_q;
                    gen_count_q  <= gen_count_q + 16'd1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q      <= S_IDLE;
                    cell_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef LIFE_SCHED_OVERRUN_CNT_EN
    logic [7:0] overrun_count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overrun_count_q <= 8'd0;
        end else if (overrun_hit && (overrun_count_q != 8'hFF)) begin
            overrun_count_q <= overrun_count_q + 8'd1;
        end
    end

    assign overrun_count_o = overrun_count_q;
`else
    assign overrun_count_o = 8'd0;
`endif

    assign cell_valid_o = cell_valid_q;
    assign cell_x_o     = cell_x_q;
    assign cell_y_o     = cell_y_q;
    assign gen_busy_o   = (state_q != S_IDLE);
    assign front_bank_o = front_bank_q;
    assign overrun_o    = overrun_q;
    assign gen_count_o  = gen_count_q;

    life_mem_arbiter #(
        .IW (IW)
    ) u_arb (
        .front_bank_i (front_bank_q),
        .disp_req_i   (disp_req_i),
        .disp_addr_i  (disp_addr_i),
        .eng_req_i    (eng_req_i),
        .eng_addr_i   (eng_addr_i),
        .eng_we_i     (eng_we_i),
        .disp_gnt_o   (disp_gnt_o),
        .eng_gnt_o    (eng_gnt_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_life_gen_scheduler.sv
// ============================================================================
//  Module  : tb_life_gen_scheduler
//  Brief   : Self-checking bench for life_gen_scheduler (default 32x24 grid).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_life_gen_scheduler;

    localparam int W  = 32;
    localparam int H  = 24;
    localparam int FD = 8;
    localparam int N  = W * H;
    localparam int IW = $clog2(N);
    localparam int AW = IW + 1;
`ifdef LIFE_SCHED_OVERRUN_CNT_EN
    localparam bit OVC_EN = 1'b1;
`else
    localparam bit OVC_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          frame_tick_i, run_i, step_i;
    logic          disp_req_i, eng_req_i, eng_we_i, cell_done_i;
    logic [IW-1:0] disp_addr_i, eng_addr_i;
    logic          disp_gnt_o, eng_gnt_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic          cell_valid_o, gen_busy_o, front_bank_o, overrun_o;
    logic [4:0]    cell_x_o;
    logic [4:0]    cell_y_o;
    logic [15:0]   gen_count_o;
    logic [7:0]    overrun_count_o;

    life_gen_scheduler #(.GRID_W(W), .GRID_H(H), .FRAME_DIV(FD)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .frame_tick_i(frame_tick_i), .run_i(run_i),
        .step_i(step_i), .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
        .eng_req_i(eng_req_i), .eng_addr_i(eng_addr_i), .eng_we_i(eng_we_i),
        .cell_done_i(cell_done_i), .disp_gnt_o(disp_gnt_o), .eng_gnt_o(eng_gnt_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .cell_valid_o(cell_valid_o),
        .cell_x_o(cell_x_o), .cell_y_o(cell_y_o), .gen_busy_o(gen_busy_o),
        .front_bank_o(front_bank_o), .overrun_o(overrun_o), .gen_count_o(gen_count_o),
        .overrun_count_o(overrun_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a generation is a linear walk over cell indices 0..N-1,
    // index N is the commit cycle, -1 means no generation in progress.
    int          m_phase;
    int          m_fc;
    logic        m_pend, m_bank, m_ovr;
    logic [15:0] m_gen;
    logic [7:0]  m_ovc;
    logic        m_trig;

    assign m_trig = frame_tick_i && ((run_i && (m_fc == FD - 1)) || m_pend);

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_phase <= -1; m_fc <= 0; m_pend <= 1'b0; m_bank <= 1'b0;
            m_gen <= 16'd0; m_ovr <= 1'b0; m_ovc <= 8'd0;
        end else begin
            m_ovr <= m_trig && (m_phase != -1);
            if (OVC_EN && m_trig && (m_phase != -1) && (m_ovc != 8'd255)) m_ovc <= m_ovc + 8'd1;
            m_fc <= !run_i ? 0 : (frame_tick_i ? ((m_fc == FD - 1) ? 0 : m_fc + 1) : m_fc);
            m_pend <= step_i ? 1'b1 : ((m_trig && m_phase == -1) ? 1'b0 : m_pend);
            if (m_phase == -1) begin
                if (m_trig) m_phase <= 0;
            end else if (m_phase == N) begin
                m_phase <= -1; m_bank <= ~m_bank; m_gen <= m_gen + 16'd1;
            end else if (cell_done_i) begin
                m_phase <= m_phase + 1;
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        logic [AW-1:0] e_addr;
        logic          valid;
        if (disp_req_i)     e_addr = {m_bank, disp_addr_i};
        else if (eng_req_i) e_addr = {(eng_we_i ? ~m_bank : m_bank), eng_addr_i};
        else                e_addr = {m_bank, disp_addr_i};
        valid = (m_phase >= 0) && (m_phase < N);
        chk("m_disp_gnt", disp_gnt_o, disp_req_i);
        chk("m_eng_gnt", eng_gnt_o, eng_req_i & ~disp_req_i);
        chk("m_mem_addr", mem_addr_o, e_addr);
        chk("m_mem_we", mem_we_o, eng_req_i & ~disp_req_i & eng_we_i);
        chk("m_cell_valid", cell_valid_o, valid);
        if (valid) begin
            chk("m_cell_x", cell_x_o, m_phase % W);
            chk("m_cell_y", cell_y_o, m_phase / W);
        end
        chk("m_gen_busy", gen_busy_o, m_phase != -1);
        chk("m_front_bank", front_bank_o, m_bank);
        chk("m_gen_count", gen_count_o, m_gen);
        chk("m_overrun", overrun_o, m_ovr);
        chk("m_overrun_count", overrun_count_o, m_ovc);
    endtask

    task automatic tick();
        @(negedge clk_i);
        check_model();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    typedef struct {
        logic          dr;
        logic [IW-1:0] da;
        logic          er;
        logic [IW-1:0] ea;
        logic          ew;
        logic          dg;
        logic          eg;
        logic          we;
        logic [AW-1:0] addr;   // expected address with front_bank = 0
    } arb_vec_t;

    arb_vec_t vecs[6];

    task automatic apply_table(input logic bank);
        for (int i = 0; i < 6; i++) begin
            tick();
            disp_req_i = vecs[i].dr; disp_addr_i = vecs[i].da;
            eng_req_i = vecs[i].er; eng_addr_i = vecs[i].ea; eng_we_i = vecs[i].ew;
            #1;
            chk("tbl_disp_gnt", disp_gnt_o, vecs[i].dg);
            chk("tbl_eng_gnt", eng_gnt_o, vecs[i].eg);
            chk("tbl_mem_we", mem_we_o, vecs[i].we);
            chk("tbl_mem_addr", mem_addr_o, vecs[i].addr ^ {bank, {IW{1'b0}}});
        end
        disp_req_i = 1'b0; eng_req_i = 1'b0; eng_we_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 10'd5,   1'b1, 10'd7,   1'b1, 1'b1, 1'b0, 1'b0, 11'd5};
        vecs[1] = '{1'b0, 10'd5,   1'b1, 10'd7,   1'b1, 1'b0, 1'b1, 1'b1, 11'd1031};
        vecs[2] = '{1'b0, 10'd5,   1'b1, 10'd9,   1'b0, 1'b0, 1'b1, 1'b0, 11'd9};
        vecs[3] = '{1'b0, 10'd100, 1'b0, 10'd9,   1'b1, 1'b0, 1'b0, 1'b0, 11'd100};
        vecs[4] = '{1'b1, 10'd767, 1'b0, 10'd9,   1'b1, 1'b1, 1'b0, 1'b0, 11'd767};
        vecs[5] = '{1'b1, 10'd3,   1'b1, 10'd700, 1'b0, 1'b1, 1'b0, 1'b0, 11'd3};

        frame_tick_i = 0; run_i = 0; step_i = 0; cell_done_i = 0;
        disp_req_i = 0; disp_addr_i = 0; eng_req_i = 0; eng_addr_i = 0; eng_we_i = 0;
        do_reset();
        tick();
        chk("rst_gen_count", gen_count_o, 0);
        chk("rst_front_bank", front_bank_o, 0);
        chk("rst_cell_valid", cell_valid_o, 0);
        chk("rst_gen_busy", gen_busy_o, 0);
        chk("rst_overrun_count", overrun_count_o, 0);

        apply_table(1'b0);

        // Single step generation walking every cell.
        do_reset();
        repeat (5) tick();
        step_i = 1; tick(); step_i = 0;
        repeat (14) tick();
        frame_tick_i = 1; tick(); frame_tick_i = 0;
        chk("step_sweep_valid", cell_valid_o, 1);
        cell_done_i = 1;
        for (int i = 0; i < N; i++) begin
            chk("walk_x", cell_x_o, i % W);
            chk("walk_y", cell_y_o, i / W);
            tick();
        end
        cell_done_i = 0;
        chk("commit_valid", cell_valid_o, 0);
        chk("commit_busy", gen_busy_o, 1);
        tick();
        chk("commit_bank", front_bank_o, 1);
        chk("commit_gen", gen_count_o, 1);
        chk("commit_idle", gen_busy_o, 0);

        apply_table(1'b1);

        // Overrun while sweeping: sweep stalls at (3,0) and must be untouched.
        step_i = 1; tick(); step_i = 0;
        frame_tick_i = 1; tick(); frame_tick_i = 0;
        cell_done_i = 1; repeat (3) tick(); cell_done_i = 0;
        step_i = 1; tick(); step_i = 0;
        frame_tick_i = 1; tick(); frame_tick_i = 0;
        chk("ovr_pulse", overrun_o, 1);
        chk("ovr_x_kept", cell_x_o, 3);
        chk("ovr_valid_kept", cell_valid_o, 1);
        tick();
        chk("ovr_pulse_end", overrun_o, 0);
        chk("ovr_count_one", overrun_count_o, OVC_EN ? 1 : 0);
        for (int i = 0; i < 299; i++) begin
            frame_tick_i = 1; tick(); frame_tick_i = 0; tick();
        end
        chk("ovr_count_sat", overrun_count_o, OVC_EN ? 255 : 0);
        cell_done_i = 1; repeat (N) tick(); cell_done_i = 0;
        tick();
        chk("ovr_gen_done", gen_count_o, 2);

        // Asynchronous reset in the middle of a sweep at (5,3).
        step_i = 1; tick(); step_i = 0;
        frame_tick_i = 1; tick(); frame_tick_i = 0;
        cell_done_i = 1; repeat (3 * W + 5) tick(); cell_done_i = 0;
        chk("mid_x", cell_x_o, 5);
        chk("mid_y", cell_y_o, 3);
        #2 reset_i = 1;
        #1;
        chk("arst_valid", cell_valid_o, 0);
        chk("arst_busy", gen_busy_o, 0);
        chk("arst_gen", gen_count_o, 0);
        chk("arst_bank", front_bank_o, 0);
        tick();
        reset_i = 0;
        step_i = 1; tick(); step_i = 0;
        frame_tick_i = 1; tick(); frame_tick_i = 0;
        chk("restart_valid", cell_valid_o, 1);
        chk("restart_x", cell_x_o, 0);
        chk("restart_y", cell_y_o, 0);

        // Automatic generations every FD frame ticks.
        do_reset();
        run_i = 1; cell_done_i = 1;
        for (int k = 1; k <= 16; k++) begin
            frame_tick_i = 1; tick(); frame_tick_i = 0;
            repeat (900) tick();
            chk("auto_gen_count", gen_count_o, k / FD);
        end
        run_i = 0; cell_done_i = 0;

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 8000; c++) begin
            tick();
            reset_i      = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 199) == 0) run_i = ~run_i;
            frame_tick_i = ($urandom_range(0, 5) == 0);
            step_i       = ($urandom_range(0, 39) == 0);
            cell_done_i  = ($urandom_range(0, 3) != 0);
            disp_req_i   = $urandom_range(0, 1) == 1;
            eng_req_i    = $urandom_range(0, 1) == 1;
            eng_we_i     = $urandom_range(0, 1) == 1;
            disp_addr_i  = IW'($urandom);
            eng_addr_i   = IW'($urandom);
        end
        reset_i = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
